// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S transmit path.
// The frame is 256 MCLK: two 32-bit slots of 4 MCLK per BCLK.
package audio_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int SLOT_BITS = 32;
    localparam int FRAME_W   = 8;

    localparam logic [FRAME_W-1:0] LOAD_L = 8'h00;
    localparam logic [FRAME_W-1:0] LOAD_R = 8'h80;

    typedef logic [23:0] sample_t;

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample input / I2S output bundle for the serializer.
// The slave side is the serializer; the master side is the upstream source and the DAC pins.
interface i2s_tx_serializer_if;
    import audio_pkg::*;

    sample_t    DATA_LEFT_IN;
    sample_t    DATA_RIGHT_IN;
    logic       SAMPLING_POINT_LEFT_IN;
    logic       SAMPLING_POINT_RIGHT_IN;
    logic       MUTE;
    logic       I2S_BCLK;
    logic       I2S_LRCK;
    logic       I2S_SDATA;
    logic [1:0] UNDERRUN;
    logic [1:0] OVERRUN;

    modport master (
        output DATA_LEFT_IN, DATA_RIGHT_IN, SAMPLING_POINT_LEFT_IN,
               SAMPLING_POINT_RIGHT_IN, MUTE,
        input  I2S_BCLK, I2S_LRCK, I2S_SDATA, UNDERRUN, OVERRUN
    );

    modport slave (
        input  DATA_LEFT_IN, DATA_RIGHT_IN, SAMPLING_POINT_LEFT_IN,
               SAMPLING_POINT_RIGHT_IN, MUTE,
        output I2S_BCLK, I2S_LRCK, I2S_SDATA, UNDERRUN, OVERRUN
    );

endinterface

// File: rtl/i2s_tx_chan.sv
// One I2S channel: a one-entry holding buffer feeding a slot shift word.
// It also raises the underrun/overrun pulses and selects the serial bit for slot position bit_idx.
module i2s_tx_chan #(
    parameter int SAMPLE_W = 24,
    parameter int J_W      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                strobe,
    input  logic [SAMPLE_W-1:0] data,
    input  logic                load,
    input  logic                mute,
    input  logic [J_W-1:0]      bit_idx,
    output logic                sdata,
    output logic                underrun,
    output logic                overrun
);

    localparam int IDX_W = $clog2(SAMPLE_W);

    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic                pend_q, pend_d;
    logic                underrun_q, underrun_d;
    logic                overrun_q, overrun_d;
    logic [IDX_W-1:0]    idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= '0;
            shift_q    <= '0;
            pend_q     <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            pend_q     <= pend_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    // A strobe coinciding with the load bypasses the buffer and counts as fresh data.
    always_comb begin
        hold_d     = hold_q;
        shift_d    = shift_q;
        pend_d     = pend_q;
        underrun_d = 1'b0;
        overrun_d  = 1'b0;
        if (load && strobe) begin
            hold_d  = data;
            shift_d = mute ? '0 : data;
            pend_d  = 1'b0;
        end else if (load) begin
            shift_d    = mute ? '0 : hold_q;
            pend_d     = 1'b0;
            underrun_d = !pend_q;
        end else if (strobe) begin
            hold_d    = data;
            pend_d    = 1'b1;
            overrun_d = pend_q;
        end
    end

    // Slot position 0 is the I2S delay bit; positions past the word are padding.
    always_comb begin
        sdata = 1'b0;
        idx   = '0;
        if (int'(bit_idx) >= 1 && int'(bit_idx) <= SAMPLE_W) begin
            idx   = IDX_W'(SAMPLE_W - int'(bit_idx));
            sdata = shift_q[idx];
        end
    end

    assign underrun = underrun_q;
    assign overrun  = overrun_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter top: frame counter, BCLK/LRCK generation and SDATA selection.
// The two channel buffers are instantiated below; every output pin is a flop.
module i2s_tx_serializer #(
    parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
    parameter int SLOT_BITS = audio_pkg::SLOT_BITS
) (
    input  logic                MCLK,
    input  logic                RESET,
    i2s_tx_serializer_if.slave  bus
);
    import audio_pkg::*;

    localparam int J_W = $clog2(SLOT_BITS);

    logic [FRAME_W-1:0] c_q, c_d;
    logic               bclk_q, bclk_d;
    logic               lrck_q, lrck_d;
    logic               sdata_q, sdata_d;
    logic [J_W-1:0]     bit_idx;
    logic               load_l, load_r;
    logic               sdata_l, sdata_r;
    logic               underrun_l, underrun_r;
    logic               overrun_l, overrun_r;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            c_q     <= 8'hFF;
            bclk_q  <= 1'b0;
            lrck_q  <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            bclk_q  <= bclk_d;
            lrck_q  <= lrck_d;
            sdata_q <= sdata_d;
        end
    end

    // Everything is decoded from the next count so the output flops line up with c.
    always_comb begin
        c_d     = c_q + FRAME_W'(1);
        bclk_d  = c_d[1];
        lrck_d  = c_d[FRAME_W-1];
        bit_idx = c_d[FRAME_W-2:2];
        load_l  = (c_d == LOAD_L);
        load_r  = (c_d == LOAD_R);
        sdata_d = lrck_d ? sdata_r : sdata_l;
    end

    i2s_tx_chan #(
        .SAMPLE_W (SAMPLE_W),
        .J_W      (J_W)
    ) u_chan_l (
        .clk      (MCLK),
        .rst      (RESET),
        .strobe   (bus.SAMPLING_POINT_LEFT_IN),
        .data     (bus.DATA_LEFT_IN),
        .load     (load_l),
        .mute     (bus.MUTE),
        .bit_idx  (bit_idx),
        .sdata    (sdata_l),
        .underrun (underrun_l),
        .overrun  (overrun_l)
    );

    i2s_tx_chan #(
        .SAMPLE_W (SAMPLE_W),
        .J_W      (J_W)
    ) u_chan_r (
        .clk      (MCLK),
        .rst      (RESET),
        .strobe   (bus.SAMPLING_POINT_RIGHT_IN),
        .data     (bus.DATA_RIGHT_IN),
        .load     (load_r),
        .mute     (bus.MUTE),
        .bit_idx  (bit_idx),
        .sdata    (sdata_r),
        .underrun (underrun_r),
        .overrun  (overrun_r)
    );

    assign bus.I2S_BCLK  = bclk_q;
    assign bus.I2S_LRCK  = lrck_q;
    assign bus.I2S_SDATA = sdata_q;
    assign bus.UNDERRUN  = {underrun_r, underrun_l};
    assign bus.OVERRUN   = {overrun_r, overrun_l};

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: whole frames are captured bit by bit
// and compared with hand-computed words and pulse counts.
module tb_i2s_tx_serializer;
    import audio_pkg::*;

    logic MCLK;
    logic RESET;
    logic [7:0] tbC;
    int checkCount;
    int passCount;

    i2s_tx_serializer_if bus();

    i2s_tx_serializer dut (
        .MCLK  (MCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // tbC is the bench's own frame count, valid 1 time unit after each rising edge.
    task automatic tick();
        @(posedge MCLK);
        #1;
        if (!RESET) tbC = tbC + 8'd1;
    endtask

    // Runs one full frame starting from tbC == FF, scheduling strobes so that the
    // edge taking c to the given value samples them, and captures both slot words.
    task automatic run_frame(input int sl1, input sample_t dl1, input int sl2, input sample_t dl2,
                             input int sr, input sample_t dr, input int mSet, input int mClr,
                             output sample_t gotL, output sample_t gotR,
                             output int unL, output int unR, output int ovL, output int ovR,
                             output int errs);
        logic [7:0] nxt;
        int jj;
        gotL = '0; gotR = '0;
        unL = 0; unR = 0; ovL = 0; ovR = 0; errs = 0;
        for (int k = 0; k < 256; k++) begin
            nxt = tbC + 8'd1;
            bus.SAMPLING_POINT_LEFT_IN  = (int'(nxt) == sl1) || (int'(nxt) == sl2);
            bus.DATA_LEFT_IN            = (int'(nxt) == sl2) ? dl2 : dl1;
            bus.SAMPLING_POINT_RIGHT_IN = (int'(nxt) == sr);
            bus.DATA_RIGHT_IN           = dr;
            if (int'(tbC) == mSet) bus.MUTE = 1'b1;
            if (int'(tbC) == mClr) bus.MUTE = 1'b0;
            tick();
            jj = int'(tbC[6:2]);
            if (bus.I2S_BCLK !== tbC[1] || bus.I2S_LRCK !== tbC[7]) errs++;
            if (jj >= 1 && jj <= 24) begin
                if (tbC[7]) gotR[5'(24 - jj)] = bus.I2S_SDATA;
                else        gotL[5'(24 - jj)] = bus.I2S_SDATA;
            end else if (bus.I2S_SDATA !== 1'b0) begin
                errs++;
            end
            if (bus.UNDERRUN[0]) unL++;
            if (bus.UNDERRUN[1]) unR++;
            if (bus.OVERRUN[0])  ovL++;
            if (bus.OVERRUN[1])  ovR++;
        end
        bus.SAMPLING_POINT_LEFT_IN  = 1'b0;
        bus.SAMPLING_POINT_RIGHT_IN = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.DATA_LEFT_IN = '0;
        bus.DATA_RIGHT_IN = '0;
        bus.SAMPLING_POINT_LEFT_IN = 1'b0;
        bus.SAMPLING_POINT_RIGHT_IN = 1'b0;
        bus.MUTE = 1'b0;
        tbC = 8'hFF;
        repeat (3) @(negedge MCLK);
        checkCount++;
        if ({bus.I2S_BCLK, bus.I2S_LRCK, bus.I2S_SDATA, bus.UNDERRUN, bus.OVERRUN} !== 7'b0)
            $display("[TB] FAIL reset_outputs got=%b exp=0000000",
                     {bus.I2S_BCLK, bus.I2S_LRCK, bus.I2S_SDATA, bus.UNDERRUN, bus.OVERRUN});
        else passCount++;
        RESET = 1'b0;
    endtask

    task automatic test_first_frame();
        sample_t gl, gr;
        int ul, ur, ol, orr, e;
        run_frame(-1, 0, -1, 0, -1, 0, -1, -1, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (e !== 0) $display("[TB] FAIL first_clocks errors=%0d exp=0", e); else passCount++;
        checkCount++;
        if (gl !== 24'h0 || gr !== 24'h0) $display("[TB] FAIL first_words got=%h/%h exp=0/0", gl, gr);
        else passCount++;
        checkCount++;
        if (ul !== 1 || ur !== 1) $display("[TB] FAIL first_underrun got=%0d/%0d exp=1/1", ul, ur);
        else passCount++;
    endtask

    task automatic test_normal();
        sample_t gl, gr;
        int ul, ur, ol, orr, e;
        run_frame(8'h40, 24'hA5A5A5, -1, 0, 8'hC0, 24'h5A5A5A, -1, -1, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (ol !== 0 || orr !== 0) $display("[TB] FAIL normal_no_overrun got=%0d/%0d exp=0/0", ol, orr);
        else passCount++;
        run_frame(-1, 0, -1, 0, -1, 0, -1, -1, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (gl !== 24'hA5A5A5) $display("[TB] FAIL normal_left got=%h exp=a5a5a5", gl); else passCount++;
        checkCount++;
        if (gr !== 24'h5A5A5A) $display("[TB] FAIL normal_right got=%h exp=5a5a5a", gr); else passCount++;
        checkCount++;
        if (ul !== 0 || ur !== 0) $display("[TB] FAIL normal_no_underrun got=%0d/%0d exp=0/0", ul, ur);
        else passCount++;
        checkCount++;
        if (e !== 0) $display("[TB] FAIL normal_clocks_padding errors=%0d exp=0", e); else passCount++;
    endtask

    task automatic test_bypass();
        sample_t gl, gr;
        int ul, ur, ol, orr, e;
        run_frame(8'h00, 24'h800001, -1, 0, -1, 0, -1, -1, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (gl !== 24'h800001) $display("[TB] FAIL bypass_left got=%h exp=800001", gl); else passCount++;
        checkCount++;
        if (ul !== 0 || ol !== 0) $display("[TB] FAIL bypass_flags got=un%0d ov%0d exp=un0 ov0", ul, ol);
        else passCount++;
        checkCount++;
        if (gr !== 24'h5A5A5A || ur !== 1)
            $display("[TB] FAIL bypass_right_repeat got=%h un%0d exp=5a5a5a un1", gr, ur);
        else passCount++;
    endtask

    task automatic test_overrun_underrun();
        sample_t gl, gr;
        int ul, ur, ol, orr, e;
        run_frame(8'h10, 24'h111111, 8'h20, 24'h222222, -1, 0, -1, -1, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (ol !== 1) $display("[TB] FAIL overrun_pulse got=%0d exp=1", ol); else passCount++;
        checkCount++;
        if (gl !== 24'h800001 || ul !== 1)
            $display("[TB] FAIL overrun_frame_left got=%h un%0d exp=800001 un1", gl, ul);
        else passCount++;
        run_frame(-1, 0, -1, 0, -1, 0, -1, -1, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (gl !== 24'h222222) $display("[TB] FAIL overrun_newest got=%h exp=222222", gl); else passCount++;
        checkCount++;
        if (ul !== 0 || ol !== 0) $display("[TB] FAIL overrun_next_flags got=un%0d ov%0d exp=un0 ov0", ul, ol);
        else passCount++;
        run_frame(-1, 0, -1, 0, -1, 0, -1, -1, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (gl !== 24'h222222 || ul !== 1)
            $display("[TB] FAIL underrun_repeat got=%h un%0d exp=222222 un1", gl, ul);
        else passCount++;
    endtask

    task automatic test_mute();
        sample_t gl, gr;
        int ul, ur, ol, orr, e;
        run_frame(8'h30, 24'h123456, -1, 0, 8'h40, 24'h654321, 8'h70, -1, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (gl !== 24'h222222) $display("[TB] FAIL mute_left_intact got=%h exp=222222", gl); else passCount++;
        checkCount++;
        if (gr !== 24'h0) $display("[TB] FAIL mute_right_zero got=%h exp=000000", gr); else passCount++;
        run_frame(-1, 0, -1, 0, -1, 0, -1, 8'hC0, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (gl !== 24'h0 || gr !== 24'h0) $display("[TB] FAIL mute_held got=%h/%h exp=0/0", gl, gr);
        else passCount++;
        checkCount++;
        if (ul !== 0 || ur !== 1) $display("[TB] FAIL mute_bookkeeping got=un%0d/%0d exp=0/1", ul, ur);
        else passCount++;
        run_frame(-1, 0, -1, 0, -1, 0, -1, -1, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (gl !== 24'h123456 || gr !== 24'h654321)
            $display("[TB] FAIL mute_resume got=%h/%h exp=123456/654321", gl, gr);
        else passCount++;
    endtask

    task automatic test_async_reset();
        sample_t gl, gr;
        int ul, ur, ol, orr, e;
        int guard;
        guard = 0;
        while (tbC != 8'h9A && guard < 300) begin
            tick();
            guard++;
        end
        checkCount++;
        if (tbC !== 8'h9A || bus.I2S_BCLK !== 1'b1 || bus.I2S_LRCK !== 1'b1)
            $display("[TB] FAIL areset_pre got=c%h bclk%b lrck%b exp=c9a bclk1 lrck1",
                     tbC, bus.I2S_BCLK, bus.I2S_LRCK);
        else passCount++;
        RESET = 1'b1;
        #1;
        checkCount++;
        if ({bus.I2S_BCLK, bus.I2S_LRCK, bus.I2S_SDATA, bus.UNDERRUN, bus.OVERRUN} !== 7'b0)
            $display("[TB] FAIL areset_immediate got=%b exp=0000000",
                     {bus.I2S_BCLK, bus.I2S_LRCK, bus.I2S_SDATA, bus.UNDERRUN, bus.OVERRUN});
        else passCount++;
        repeat (2) @(negedge MCLK);
        tbC = 8'hFF;
        RESET = 1'b0;
        run_frame(-1, 0, -1, 0, -1, 0, -1, -1, gl, gr, ul, ur, ol, orr, e);
        checkCount++;
        if (gl !== 24'h0 || gr !== 24'h0 || e !== 0)
            $display("[TB] FAIL areset_restart got=%h/%h errs%0d exp=0/0 errs0", gl, gr, e);
        else passCount++;
        checkCount++;
        if (ul !== 1 || ur !== 1) $display("[TB] FAIL areset_underrun got=%0d/%0d exp=1/1", ul, ur);
        else passCount++;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        test_reset();
        test_first_frame();
        test_normal();
        test_bypass();
        test_overrun_underrun();
        test_mute();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
